// File: rtl/pe_dc_pkg.sv
// Shared widths, batch-norm threshold helper and FSM state encoding for the
// time-multiplexed binary deconvolution PE (pe_dc_tm).
package pe_dc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_FLUSH,
    ST_OUT
  } state_e;

  function automatic int acc_w(input int d, input int fh, input int fw);
    return $clog2(d * fh * fw + 1);
  endfunction

  function automatic int pindex_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

  // The threshold width guarantees the sum never overflows, so a 32-bit signed
  // evaluation floors exactly as the narrow NORMREF_WIDTH+1 form would.
  function automatic int threshold(input int d, input int fh, input int fw, input int norm_ref);
    return (d * fh * fw + norm_ref) >>> 1;
  endfunction

endpackage

// File: rtl/pe_dc_tm_if.sv
// Beat-input / result-output bundle for pe_dc_tm; master drives beats and
// out_ready, slave is the processing element.
interface pe_dc_tm_if
  import pe_dc_pkg::*;
#(
  parameter int DSLICE        = 64,
  parameter int FH            = 3,
  parameter int FW            = 3,
  parameter int N_KERNEL      = 4,
  parameter int NORMREF_WIDTH = 13,
  parameter int P             = 4
);
  localparam int BEAT_W   = DSLICE * FH * FW;
  localparam int PINDEX_W = pindex_w(P);

  logic                              in_valid;
  logic                              in_ready;
  logic [BEAT_W-1:0]                 data_in;
  logic [N_KERNEL*BEAT_W-1:0]        weight_in;
  logic [N_KERNEL*NORMREF_WIDTH-1:0] norm_ref;
  logic [PINDEX_W-1:0]               pindex;
  logic                              s;
  logic                              out_valid;
  logic                              out_ready;
  logic [N_KERNEL*P-1:0]             data_out;

  modport master (
    output in_valid, data_in, weight_in, norm_ref, pindex, s, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, weight_in, norm_ref, pindex, s, out_ready,
    output in_ready, out_valid, data_out
  );

endinterface

// File: rtl/pe_dc_popcnt.sv
// XNOR-popcount of one binary slice against one kernel's weights.
module pe_dc_popcnt #(
  parameter  int W  = 576,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data_i,
  input  logic [W-1:0]  weight_i,
  output logic [CW-1:0] count_o
);

  logic [W-1:0] match;

  assign match = ~(data_i ^ weight_i);

  // NOTE: every always_comb output gets a default first so no latch can form.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CW'(match[i]);
    end
  end

endmodule

// File: rtl/pe_dc_tm.sv
// Multi-kernel XNOR-popcount PE with BN threshold, binarise and unpool.
// Define PE_DC_TM_POPCNT_REG_EN to register popcounts before the accumulators.
module pe_dc_tm
  import pe_dc_pkg::*;
#(
  parameter int D             = 512,
  parameter int DSLICE        = 64,
  parameter int FH            = 3,
  parameter int FW            = 3,
  parameter int POOL_H        = 2,
  parameter int POOL_W        = 2,
  parameter int N_KERNEL      = 4,
  parameter int NORMREF_WIDTH = 13
) (
  input logic        clk,
  input logic        rst,
  pe_dc_tm_if.slave  bus
);

  localparam int P        = POOL_H * POOL_W;
  localparam int NBEAT    = D / DSLICE;
  localparam int BEAT_W   = DSLICE * FH * FW;
  localparam int ACC_W    = acc_w(D, FH, FW);
  localparam int PC_W     = $clog2(BEAT_W + 1);
  localparam int PIDX_W   = pindex_w(P);
  localparam int CNT_W    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int NRW      = NORMREF_WIDTH;
`ifdef PE_DC_TM_POPCNT_REG_EN
  localparam int FLUSH_CYC = 2;
`else
  localparam int FLUSH_CYC = 1;
`endif

  state_e                          state_q;
  logic [CNT_W-1:0]                beat_cnt_q;
  logic                            flush_cnt_q;
  logic [N_KERNEL-1:0][NRW-1:0]    norm_ref_q;
  logic [PIDX_W-1:0]               pindex_q;
  logic                            s_q;
  logic [N_KERNEL*P-1:0]           data_out_q;
  logic                            out_valid_q;
  logic                            in_ready_q;
  logic [N_KERNEL-1:0][ACC_W-1:0]  acc_q;

  logic                            beat_fire;
  logic                            last_beat;
  logic                            flush_done;
  logic [N_KERNEL-1:0][PC_W-1:0]   pc;
  logic                            add_en;
  logic                            add_first;
  logic [N_KERNEL-1:0][PC_W-1:0]   add_pc;
  logic [N_KERNEL-1:0]             bit_d;
  logic [N_KERNEL*P-1:0]           result_d;

  assign bus.in_ready  = in_ready_q & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;

  assign beat_fire  = bus.in_valid & bus.in_ready;
  assign last_beat  = (beat_cnt_q == CNT_W'(NBEAT - 1));
  assign flush_done = (flush_cnt_q == 1'(FLUSH_CYC - 1));

  for (genvar k = 0; k < N_KERNEL; k++) begin : g_kernel
    pe_dc_popcnt #(.W(BEAT_W)) u_popcnt (
      .data_i   (bus.data_in),
      .weight_i (bus.weight_in[k*BEAT_W +: BEAT_W]),
      .count_o  (pc[k])
    );
  end

`ifdef PE_DC_TM_POPCNT_REG_EN
  logic [N_KERNEL-1:0][PC_W-1:0] pc_q;
  logic                          pc_vld_q;
  logic                          pc_first_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      pc_vld_q   <= 1'b0;
      pc_first_q <= 1'b0;
    end else begin
      pc_vld_q   <= beat_fire;
      pc_first_q <= (beat_cnt_q == '0);
      if (beat_fire) pc_q <= pc;
    end
  end

  assign add_en    = pc_vld_q;
  assign add_first = pc_first_q;
  assign add_pc    = pc_q;
`else
  assign add_en    = beat_fire;
  assign add_first = (beat_cnt_q == '0);
  assign add_pc    = pc;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (add_en) begin
      for (int k = 0; k < N_KERNEL; k++) begin
        acc_q[k] <= add_first ? ACC_W'(add_pc[k]) : acc_q[k] + ACC_W'(add_pc[k]);
      end
    end
  end

  always_comb begin
    bit_d    = '0;
    result_d = '0;
    for (int k = 0; k < N_KERNEL; k++) begin
      bit_d[k] = (int'(acc_q[k]) >= threshold(D, FH, FW, int'($signed(norm_ref_q[k])))) ^ s_q;
      if (P == 1) begin
        result_d[k] = bit_d[k];
      end else if (int'(pindex_q) < P) begin
        result_d[k*P + int'(pindex_q)] = bit_d[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      flush_cnt_q <= 1'b0;
      norm_ref_q  <= '0;
      pindex_q    <= '0;
      s_q         <= 1'b0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      if (beat_fire) beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (beat_fire) begin
            norm_ref_q <= bus.norm_ref;
            pindex_q   <= bus.pindex;
            s_q        <= bus.s;
            if (last_beat) begin
              state_q    <= ST_FLUSH;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= ST_ACC;
            end
          end
        end
        ST_ACC: begin
          if (beat_fire && last_beat) begin
            state_q    <= ST_FLUSH;
            in_ready_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (flush_done) begin
            flush_cnt_q <= 1'b0;
            data_out_q  <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
